// File: rtl/riscv_pkg.sv
// Shared encodings for the piRISC multicycle sequencer: opcodes, FSM states,
// instruction classes and the PC-select codes understood by PC_controller.
package riscv_pkg;

  // RV32I major opcodes (IR[6:0])
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_HALT      = 3'd6
  } state_e;

  // Instruction classes latched in DECODE; ALU covers OP/OP-IMM/LUI/AUIPC
  typedef enum logic [2:0] {
    CL_ALU     = 3'd0,
    CL_LOAD    = 3'd1,
    CL_STORE   = 3'd2,
    CL_BRANCH  = 3'd3,
    CL_JAL     = 3'd4,
    CL_JALR    = 3'd5,
    CL_SYSTEM  = 3'd6,
    CL_ILLEGAL = 3'd7
  } iclass_e;

  // PC-select codes shared with PC_controller
  localparam logic [1:0] NORMALOP  = 2'b00;
  localparam logic [1:0] BRANCHING = 2'b01;
  localparam logic [1:0] JAL       = 2'b10;
  localparam logic [1:0] JALR      = 2'b11;

  // Map a major opcode onto the sequencer's instruction class
  function automatic iclass_e classify_opcode(input logic [6:0] opc);
    iclass_e cls;
    case (opc)
      OPC_LOAD:   cls = CL_LOAD;
      OPC_STORE:  cls = CL_STORE;
      OPC_BRANCH: cls = CL_BRANCH;
      OPC_JAL:    cls = CL_JAL;
      OPC_JALR:   cls = CL_JALR;
      OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: cls = CL_ALU;
      OPC_SYSTEM: cls = CL_SYSTEM;
      default:    cls = CL_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Memory-handshake watchdog: counts waiting cycles and flags the cycle on
// which the wait budget of MEM_TIMEOUT cycles is used up.
module seq_watchdog #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(MEM_TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: hold at zero outside waits, count each unanswered cycle
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = {CW{1'b0}};
    end else if (enable && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The MEM_TIMEOUT-th waiting cycle with ready still low is the last one
  assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/instr_sequencer.sv
// Multicycle control FSM for the piRISC core: steps each instruction through
// fetch, decode, execute, memory and writeback, driving the memory
// handshakes, register-file write enable and PC update strobe.
module instr_sequencer
  import riscv_pkg::*;
#(
  parameter int CNT_WIDTH   = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic [6:0]           opcode,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  output logic                 imem_req,
  output logic                 ir_load,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic                 rf_we,
  output logic                 pc_en,
  output logic [1:0]           pc_select,
  output logic                 halted,
  output logic                 fault,
  output logic [CNT_WIDTH-1:0] retired
);

  state_e                 state_q, state_d;
  iclass_e                class_q, class_d;
  logic                   fault_q, fault_d;
  logic [CNT_WIDTH-1:0]   retired_q, retired_d;

  logic wd_clear;
  logic wd_enable;
  logic wd_expired;

  // Watchdog only runs in the two handshake wait states
  assign wd_clear  = (state_q != ST_FETCH) && (state_q != ST_MEMORY);
  assign wd_enable = ((state_q == ST_FETCH) && !imem_ready) ||
                     ((state_q == ST_MEMORY) && !dmem_ready);

  seq_watchdog #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (reset),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  // Next-state, class capture, fault cause and retire count
  always_comb begin
    state_d   = state_q;
    class_d   = class_q;
    fault_d   = fault_q;
    retired_d = retired_q;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
        else     state_d = ST_IDLE;
      end
      ST_FETCH: begin
        if (imem_ready) begin
          state_d = ST_DECODE;
        end else if (wd_expired) begin
          state_d = ST_HALT;
          fault_d = 1'b1;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        class_d = classify_opcode(opcode);
        case (class_d)
          CL_SYSTEM: begin
            state_d = ST_HALT;
            fault_d = 1'b0;
          end
          CL_ILLEGAL: begin
            state_d = ST_HALT;
            fault_d = 1'b1;
          end
          default: state_d = ST_EXECUTE;
        endcase
      end
      ST_EXECUTE: begin
        if ((class_q == CL_LOAD) || (class_q == CL_STORE)) state_d = ST_MEMORY;
        else                                                state_d = ST_WRITEBACK;
      end
      ST_MEMORY: begin
        if (dmem_ready) begin
          state_d = ST_WRITEBACK;
        end else if (wd_expired) begin
          state_d = ST_HALT;
          fault_d = 1'b1;
        end else begin
          state_d = ST_MEMORY;
        end
      end
      ST_WRITEBACK: begin
        retired_d = retired_q + CNT_WIDTH'(1);
        if (run) state_d = ST_FETCH;
        else     state_d = ST_IDLE;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, class, fault and counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      class_q   <= CL_ALU;
      fault_q   <= 1'b0;
      retired_q <= {CNT_WIDTH{1'b0}};
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      fault_q   <= fault_d;
      retired_q <= retired_d;
    end
  end

  // Moore output decode from state and latched class (ir_load also sees imem_ready)
  always_comb begin
    imem_req  = 1'b0;
    ir_load   = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    rf_we     = 1'b0;
    pc_en     = 1'b0;
    pc_select = NORMALOP;
    halted    = 1'b0;
    case (state_q)
      ST_FETCH: begin
        imem_req = 1'b1;
        ir_load  = imem_ready;
      end
      ST_MEMORY: begin
        dmem_req = 1'b1;
        dmem_we  = (class_q == CL_STORE);
      end
      ST_WRITEBACK: begin
        pc_en = 1'b1;
        if ((class_q == CL_STORE) || (class_q == CL_BRANCH)) rf_we = 1'b0;
        else                                                 rf_we = 1'b1;
        case (class_q)
          CL_BRANCH: pc_select = BRANCHING;
          CL_JAL:    pc_select = JAL;
          CL_JALR:   pc_select = JALR;
          default:   pc_select = NORMALOP;
        endcase
      end
      ST_HALT: halted = 1'b1;
      default: halted = 1'b0;
    endcase
  end

  assign fault   = fault_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: scripted scenarios plus randomized instruction
// streams, each cycle compared against expectations derived from the
// documented per-phase output rules and a simple retired-instruction count.
module tb_instr_sequencer;

  localparam int CW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          run;
  logic [6:0]    opcode;
  logic          imem_ready;
  logic          dmem_ready;
  logic          imem_req;
  logic          ir_load;
  logic          dmem_req;
  logic          dmem_we;
  logic          rf_we;
  logic          pc_en;
  logic [1:0]    pc_select;
  logic          halted;
  logic          fault;
  logic [CW-1:0] retired;

  int            compared   = 0;
  int            mismatched = 0;
  logic [CW-1:0] exp_retired;

  typedef struct packed {
    logic       legal;
    logic       sys;
    logic       mem;
    logic       store;
    logic       rfw;
    logic [1:0] pcs;
  } ref_t;

  instr_sequencer #(
    .CNT_WIDTH  (CW),
    .MEM_TIMEOUT(TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .opcode    (opcode),
    .imem_ready(imem_ready),
    .dmem_ready(dmem_ready),
    .imem_req  (imem_req),
    .ir_load   (ir_load),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .rf_we     (rf_we),
    .pc_en     (pc_en),
    .pc_select (pc_select),
    .halted    (halted),
    .fault     (fault),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  // Observed outputs packed as {imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_en, pc_select, halted, fault}
  function automatic logic [9:0] obs();
    return {imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_en, pc_select, halted, fault};
  endfunction

  // Behaviour of each opcode as listed in the instruction table
  function automatic ref_t ref_class(input logic [6:0] o);
    ref_t r;
    r = '0;
    r.legal = 1'b1;
    r.rfw   = 1'b1;
    case (o)
      7'b0000011: r.mem = 1'b1;
      7'b0100011: begin r.mem = 1'b1; r.store = 1'b1; r.rfw = 1'b0; end
      7'b1100011: begin r.rfw = 1'b0; r.pcs = 2'b01; end
      7'b1101111: r.pcs = 2'b10;
      7'b1100111: r.pcs = 2'b11;
      7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: r.pcs = 2'b00;
      7'b1110011: r.sys = 1'b1;
      default:    r.legal = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [6:0] pick_legal(input int i);
    case (i)
      0: return 7'b0000011;
      1: return 7'b0100011;
      2: return 7'b1100011;
      3: return 7'b1101111;
      4: return 7'b1100111;
      5: return 7'b0110011;
      6: return 7'b0010011;
      7: return 7'b0110111;
      default: return 7'b0010111;
    endcase
  endfunction

  task automatic apply_reset();
    reset = 1'b0;
    run = 1'($urandom); imem_ready = 1'b1; dmem_ready = 1'b1;
    #1;
    compared++;
    if (obs() !== 10'b0) begin
      mismatched++;
      $display("FAIL reset_outputs: got %b expected %b", obs(), 10'b0);
    end
    compared++;
    if (retired !== {CW{1'b0}}) begin
      mismatched++;
      $display("FAIL reset_retired: got %0d expected 0", retired);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    run = 1'b0;
    exp_retired = '0;
  endtask

  // IDLE for n cycles; if start, run is raised on the last one
  task automatic idle_cycles(input int n, input logic start);
    for (int k = 0; k < n; k++) begin
      run = start && (k == n - 1);
      imem_ready = 1'($urandom); dmem_ready = 1'($urandom); opcode = 7'($urandom);
      @(negedge clk);
      compared++;
      if (obs() !== 10'b0) begin
        mismatched++;
        $display("FAIL idle[%0d]: got %b expected %b", k, obs(), 10'b0);
      end
      compared++;
      if (retired !== exp_retired) begin
        mismatched++;
        $display("FAIL idle_retired: got %0d expected %0d", retired, exp_retired);
      end
      @(posedge clk); #1;
    end
  endtask

  // HALT is absorbing: hold and check for a few cycles
  task automatic check_halt_state(input logic f);
    for (int k = 0; k < 3; k++) begin
      run = 1'($urandom); imem_ready = 1'($urandom); dmem_ready = 1'($urandom);
      @(negedge clk);
      compared++;
      if (obs() !== {8'b0, 1'b1, f}) begin
        mismatched++;
        $display("FAIL halt[%0d]: got %b expected %b", k, obs(), {8'b0, 1'b1, f});
      end
      compared++;
      if (retired !== exp_retired) begin
        mismatched++;
        $display("FAIL halt_retired: got %0d expected %0d", retired, exp_retired);
      end
      @(posedge clk); #1;
    end
  endtask

  // One instruction starting in FETCH; iw/dw = ready delay in cycles (>=TO means never)
  task automatic do_instr(input logic [6:0] opc, input int iw, input int dw, input logic run_wb);
    ref_t       c;
    logic [9:0] e;
    c = ref_class(opc);
    for (int k = 0; k < TO; k++) begin
      imem_ready = (k == iw); dmem_ready = 1'($urandom);
      run = 1'($urandom); opcode = 7'($urandom);
      e = {1'b1, imem_ready, 8'b0};
      @(negedge clk);
      compared++;
      if (obs() !== e) begin
        mismatched++;
        $display("FAIL fetch[%0d] opc=%b: got %b expected %b", k, opc, obs(), e);
      end
      @(posedge clk); #1;
      if (k == iw) break;
    end
    if (iw >= TO) begin
      check_halt_state(1'b1);
      return;
    end
    opcode = opc; imem_ready = 1'($urandom); dmem_ready = 1'($urandom); run = 1'($urandom);
    @(negedge clk);
    compared++;
    if (obs() !== 10'b0) begin
      mismatched++;
      $display("FAIL decode opc=%b: got %b expected %b", opc, obs(), 10'b0);
    end
    @(posedge clk); #1;
    if (!c.legal || c.sys) begin
      check_halt_state(!c.legal);
      return;
    end
    run = run_wb ? 1'($urandom) : 1'b0;
    imem_ready = 1'($urandom); dmem_ready = 1'($urandom);
    @(negedge clk);
    compared++;
    if (obs() !== 10'b0) begin
      mismatched++;
      $display("FAIL execute opc=%b: got %b expected %b", opc, obs(), 10'b0);
    end
    @(posedge clk); #1;
    if (c.mem) begin
      for (int k = 0; k < TO; k++) begin
        dmem_ready = (k == dw); imem_ready = 1'($urandom);
        run = run_wb ? 1'($urandom) : 1'b0;
        e = {2'b00, 1'b1, c.store, 6'b0};
        @(negedge clk);
        compared++;
        if (obs() !== e) begin
          mismatched++;
          $display("FAIL memory[%0d] opc=%b: got %b expected %b", k, opc, obs(), e);
        end
        @(posedge clk); #1;
        if (k == dw) break;
      end
      if (dw >= TO) begin
        check_halt_state(1'b1);
        return;
      end
    end
    run = run_wb; imem_ready = 1'($urandom); dmem_ready = 1'($urandom);
    e = {4'b0, c.rfw, 1'b1, c.pcs, 2'b00};
    @(negedge clk);
    compared++;
    if (obs() !== e) begin
      mismatched++;
      $display("FAIL writeback opc=%b: got %b expected %b", opc, obs(), e);
    end
    compared++;
    if (retired !== exp_retired) begin
      mismatched++;
      $display("FAIL wb_retired: got %0d expected %0d", retired, exp_retired);
    end
    @(posedge clk); #1;
    exp_retired = exp_retired + CW'(1);
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b0; opcode = 7'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    exp_retired = '0;
    #2;
    apply_reset();
    idle_cycles(3, 1'b0);
  endtask

  task automatic test_op_imm();
    idle_cycles(1, 1'b1);
    do_instr(7'b0010011, 0, 0, 1'b1);
  endtask

  task automatic test_load_store();
    do_instr(7'b0000011, 0, 3, 1'b1);
    do_instr(7'b0100011, 0, 3, 1'b1);
  endtask

  task automatic test_back_to_back();
    do_instr(7'b1100011, 0, 0, 1'b1);
    do_instr(7'b1101111, 0, 0, 1'b1);
    do_instr(7'b1100111, 0, 0, 1'b1);
  endtask

  task automatic test_run_stop();
    do_instr(7'b0110011, 0, 0, 1'b0);
    idle_cycles(3, 1'b1);
  endtask

  task automatic test_random();
    logic rw;
    for (int n = 0; n < 40; n++) begin
      rw = ($urandom_range(0, 3) != 0);
      do_instr(pick_legal($urandom_range(0, 8)), $urandom_range(0, 4), $urandom_range(0, 4), rw);
      if (!rw) idle_cycles($urandom_range(1, 3), 1'b1);
    end
  endtask

  task automatic test_illegal_and_ecall();
    do_instr(7'b0000000, 0, 0, 1'b1);
    apply_reset();
    idle_cycles(1, 1'b1);
    do_instr(7'b0110011, 0, 0, 1'b1);
    do_instr(7'b1110011, 1, 0, 1'b1);
    apply_reset();
    idle_cycles(1, 1'b1);
    do_instr(7'b1111111, 2, 0, 1'b1);
    apply_reset();
  endtask

  task automatic test_timeout();
    idle_cycles(1, 1'b1);
    do_instr(7'b0000011, 0, TO, 1'b1);
    apply_reset();
    idle_cycles(1, 1'b1);
    do_instr(7'b0000011, 0, TO - 1, 1'b0);
    idle_cycles(1, 1'b1);
    do_instr(7'b0110011, TO, 0, 1'b1);
    apply_reset();
    idle_cycles(1, 1'b1);
    do_instr(7'b0100011, TO - 1, 2, 1'b0);
  endtask

  task automatic test_reset_mid_memory();
    idle_cycles(1, 1'b1);
    run = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b0;
    @(posedge clk); #1;
    imem_ready = 1'b0; opcode = 7'b0000011;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    compared++;
    if (obs() !== {2'b00, 1'b1, 7'b0}) begin
      mismatched++;
      $display("FAIL mid_memory: got %b expected %b", obs(), {2'b00, 1'b1, 7'b0});
    end
    #1;
    reset = 1'b0;
    #1;
    compared++;
    if (obs() !== 10'b0) begin
      mismatched++;
      $display("FAIL async_reset_outputs: got %b expected %b", obs(), 10'b0);
    end
    compared++;
    if (retired !== {CW{1'b0}}) begin
      mismatched++;
      $display("FAIL async_reset_retired: got %0d expected 0", retired);
    end
    @(posedge clk); #1;
    reset = 1'b1; run = 1'b0;
    exp_retired = '0;
    idle_cycles(2, 1'b0);
  endtask

  initial begin
    test_reset();
    test_op_imm();
    test_load_store();
    test_back_to_back();
    test_run_stop();
    test_random();
    test_illegal_and_ecall();
    test_timeout();
    test_reset_mid_memory();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
